// File: rtl/spi_slave_gen.sv
// -----------------------------------------------------------------------------
// spi_slave_gen
//
// Parametrised SPI slave that runs entirely in the CLK domain. SCLK, MOSI and
// CS are oversampled through SYNC_STAGES-deep synchronisers. All four SPI
// modes and MSB/LSB-first order are supported. Mode and bit order are latched
// at CS assertion. Multi-word bursts run while CS stays low. Transmit data
// enters through a ready/valid holding register that feeds a shift register.
//
// Ports
//   CLK          system clock, rising edge
//   reset        synchronous, active-high reset
//   SCLK/MOSI/CS SPI pins from the master (asynchronous to CLK, CS active low)
//   mode         {CPOL, CPHA}, captured at CS assertion
//   lsb_first    1 = LSB first, captured at CS assertion
//   tx_data/tx_valid/tx_ready   transmit handshake into the holding register
//   MISO         registered serial output, 0 while deselected
//   rx_data      last complete received word; rx_valid pulses when it updates
//   tx_underrun  pulse: a word started with an empty holding register
//   frame_err    pulse: CS deasserted mid-word
//   busy         frame active
// -----------------------------------------------------------------------------
module spi_slave_gen #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  SCLK,
  input  logic                  MOSI,
  input  logic                  CS,
  input  logic [1:0]            mode,
  input  logic                  lsb_first,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  MISO,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, WAIT_CS} state_t;

  state_t state, state_next;

  // Synchronisers and edge-detect history
  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
  logic                   sclk_d, cs_d;
  logic                   s_sclk, s_mosi, s_cs;

  // Per-frame configuration
  logic cpol_q, cpha_q, lsb_q;

  // Receive path
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] rx_shift, rx_next;

  // Transmit path
  logic [DATA_WIDTH-1:0] hold_reg, tx_shift, load_word;
  logic                  hold_full;

  // Decoded events
  logic sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic in_frame, sample_edge, shift_edge, word_done;
  logic cs_fall, frame_start, frame_end;
  logic tx_load, tx_accept;

  assign s_sclk = sclk_sync[SYNC_STAGES-1];
  assign s_mosi = mosi_sync[SYNC_STAGES-1];
  assign s_cs   = cs_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Synchronisers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (reset) begin
      // NOTE: the CS chain resets to 0 (selected) so a frame still in progress
      // when reset releases never shows a falling edge; WAIT_CS then holds off
      // until CS is genuinely seen high.
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // here samples the pre-edge value of the one before it.
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      sclk_d    <= s_sclk;
      cs_d      <= s_cs;
    end
  end

  // ---------------------------------------------------------------------------
  // Edge decode
  // ---------------------------------------------------------------------------
  assign sclk_rise  = s_sclk & ~sclk_d;
  assign sclk_fall  = ~s_sclk & sclk_d;
  assign lead_edge  = cpol_q ? sclk_fall : sclk_rise;
  assign trail_edge = cpol_q ? sclk_rise : sclk_fall;

  assign cs_fall     = cs_d & ~s_cs;
  assign frame_start = (state == IDLE) & cs_fall;
  assign frame_end   = (state == ACTIVE) & s_cs;

  // A CS rise in the same cycle as an SCLK edge suppresses that edge.
  assign in_frame    = (state == ACTIVE) & ~s_cs;
  assign sample_edge = in_frame & (cpha_q ? trail_edge : lead_edge);
  assign shift_edge  = in_frame & (cpha_q ? lead_edge : trail_edge);
  assign word_done   = sample_edge & (bit_cnt == LAST_BIT);

  assign rx_next = lsb_q ? {s_mosi, rx_shift[DATA_WIDTH-1:1]}
                         : {rx_shift[DATA_WIDTH-2:0], s_mosi};

  assign tx_load   = frame_start | word_done;
  assign tx_accept = tx_valid & ~hold_full;
  assign load_word = hold_full ? hold_reg : '0;

  assign tx_ready = ~hold_full;
  assign busy     = (state == ACTIVE);

  // ---------------------------------------------------------------------------
  // Frame state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (reset) state <= WAIT_CS;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: default assigned first so every path drives state_next and no
    // latch is inferred.
    state_next = state;
    case (state)
      WAIT_CS: if (s_cs)    state_next = IDLE;
      IDLE:    if (cs_fall) state_next = ACTIVE;
      ACTIVE:  if (s_cs)    state_next = IDLE;
      default:              state_next = WAIT_CS;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (reset) begin
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      lsb_q       <= 1'b0;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;
      hold_reg    <= '0;
      hold_full   <= 1'b0;
      tx_shift    <= '0;
      MISO        <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;

      if (frame_start) begin
        cpol_q  <= mode[1];
        cpha_q  <= mode[0];
        lsb_q   <= lsb_first;
        bit_cnt <= '0;
      end

      // Receive: shift in on each sample edge, publish on the last bit.
      if (sample_edge) begin
        rx_shift <= rx_next;
        if (word_done) begin
          bit_cnt  <= '0;
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end

      if (frame_end && (bit_cnt != '0)) frame_err <= 1'b1;

      // Holding register: a load takes the old content even when a new word
      // is accepted in the same cycle.
      if (tx_accept) begin
        hold_reg  <= tx_data;
        hold_full <= 1'b1;
      end else if (tx_load) begin
        hold_full <= 1'b0;
      end
      if (tx_load) tx_underrun <= ~hold_full;

      // Transmit shift register. With CPHA=0 the first bit of a frame is
      // presented straight from the load, so the register starts one bit on.
      if (frame_start) begin
        if (mode[0]) tx_shift <= load_word;
        else         tx_shift <= lsb_first ? (load_word >> 1) : (load_word << 1);
      end else if (word_done) begin
        tx_shift <= load_word;
      end else if (shift_edge) begin
        tx_shift <= lsb_q ? (tx_shift >> 1) : (tx_shift << 1);
      end

      if (frame_start) begin
        if (mode[0]) MISO <= 1'b0;
        else         MISO <= lsb_first ? load_word[0] : load_word[DATA_WIDTH-1];
      end else if (!in_frame) begin
        MISO <= 1'b0;
      end else if (shift_edge) begin
        MISO <= lsb_q ? tx_shift[0] : tx_shift[DATA_WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_gen.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_gen
//
// Directed bench for spi_slave_gen. An 8-bit and a 12-bit instance share the
// SCLK/MOSI pins and have separate chip selects. A behavioural SPI master task
// drives frames and captures MISO. A negedge monitor counts the rx_valid,
// tx_underrun and frame_err pulses and logs the received words.
// -----------------------------------------------------------------------------
module tb_spi_slave_gen;

  localparam int HALF  = 8;   // SCLK half period in CLK cycles
  localparam int SETUP = 10;  // CS fall to first SCLK edge in CLK cycles

  logic        clk = 1'b0;
  logic        reset;
  logic        sclk, mosi, cs_lvl, sel12;
  logic [1:0]  mode_pin;
  logic        lsb_pin;
  logic [31:0] tx_word;
  logic        txv8, txv12;

  logic        cs8, cs12;
  logic        tx_ready8, miso8, rx_valid8, und8, fe8, busy8;
  logic [7:0]  rx_data8;
  logic        tx_ready12, miso12, rx_valid12, und12, fe12, busy12;
  logic [11:0] rx_data12;

  assign cs8  = sel12 ? 1'b1 : cs_lvl;
  assign cs12 = sel12 ? cs_lvl : 1'b1;

  always #5 clk = ~clk;

  spi_slave_gen #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .CLK(clk), .reset(reset), .SCLK(sclk), .MOSI(mosi), .CS(cs8),
    .mode(mode_pin), .lsb_first(lsb_pin),
    .tx_data(tx_word[7:0]), .tx_valid(txv8), .tx_ready(tx_ready8),
    .MISO(miso8), .rx_data(rx_data8), .rx_valid(rx_valid8),
    .tx_underrun(und8), .frame_err(fe8), .busy(busy8)
  );

  spi_slave_gen #(.DATA_WIDTH(12), .SYNC_STAGES(2)) dut12 (
    .CLK(clk), .reset(reset), .SCLK(sclk), .MOSI(mosi), .CS(cs12),
    .mode(mode_pin), .lsb_first(lsb_pin),
    .tx_data(tx_word[11:0]), .tx_valid(txv12), .tx_ready(tx_ready12),
    .MISO(miso12), .rx_data(rx_data12), .rx_valid(rx_valid12),
    .tx_underrun(und12), .frame_err(fe12), .busy(busy12)
  );

  // ---------------------------------------------------------------------------
  // Pulse monitor (index 0 = 8-bit instance, 1 = 12-bit instance)
  // ---------------------------------------------------------------------------
  int          rxv_cnt [2];
  int          und_cnt [2];
  int          fe_cnt  [2];
  int          und_at  [2][16];
  logic [31:0] rx_log  [2][16];

  always @(negedge clk) begin
    if (rx_valid8) begin
      rx_log[0][rxv_cnt[0] % 16] = 32'(rx_data8);
      rxv_cnt[0]++;
    end
    if (rx_valid12) begin
      rx_log[1][rxv_cnt[1] % 16] = 32'(rx_data12);
      rxv_cnt[1]++;
    end
    if (und8) begin
      und_at[0][und_cnt[0] % 16] = rxv_cnt[0];
      und_cnt[0]++;
    end
    if (und12) begin
      und_at[1][und_cnt[1] % 16] = rxv_cnt[1];
      und_cnt[1]++;
    end
    if (fe8)  fe_cnt[0]++;
    if (fe12) fe_cnt[1]++;
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"},     32'(miso8),      32'h0);
    check({tag, "_rx_data"},  32'(rx_data8),   32'h0);
    check({tag, "_rx_valid"}, 32'(rx_valid8),  32'h0);
    check({tag, "_underrun"}, 32'(und8),       32'h0);
    check({tag, "_frame_err"},32'(fe8),        32'h0);
    check({tag, "_busy"},     32'(busy8),      32'h0);
    check({tag, "_tx_ready"}, 32'(tx_ready8),  32'h1);
    check({tag, "_rx12"},     32'(rx_data12),  32'h0);
    check({tag, "_ready12"},  32'(tx_ready12), 32'h1);
  endtask

  // Offer one word to the holding register and wait (bounded) for the accept.
  task automatic push_tx(input logic sel, input logic [31:0] d);
    int n;
    n       = 0;
    tx_word = d;
    txv8    = ~sel;
    txv12   = sel;
    while (!(sel ? tx_ready12 : tx_ready8) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL push_tx_timeout: tx_ready never rose for 0x%0h", d);
    end
    @(negedge clk);
    txv8  = 1'b0;
    txv12 = 1'b0;
    check("tx_ready_after_accept", 32'(sel ? tx_ready12 : tx_ready8), 32'h0);
  endtask

  function automatic int bpos(input int b, input int w, input logic lsb);
    return lsb ? (b % w) : (w - 1 - (b % w));
  endfunction

  // Behavioural SPI master. stop_bits >= 0 aborts the frame after that many
  // bits; rst_after > 0 pulses reset after that many bits with CS still low.
  task automatic spi_frame(input logic sel, input logic [1:0] md, input logic lsb,
                           input int w, input int nw, input logic [2:0][31:0] mo,
                           input int stop_bits, input int rst_after,
                           output logic [2:0][31:0] mi);
    int   total, wi, nb;
    logic cpol, cpha;
    total = (stop_bits >= 0) ? stop_bits : nw * w;
    cpol  = md[1];
    cpha  = md[0];
    mi    = '0;
    @(negedge clk);
    sel12    = sel;
    mode_pin = md;
    lsb_pin  = lsb;
    sclk     = cpol;
    wait_clk(4);
    cs_lvl = 1'b0;
    if (!cpha) mosi = mo[0][bpos(0, w, lsb)];
    wait_clk(SETUP);
    check("busy_in_frame", 32'(sel ? busy12 : busy8), 32'h1);
    // Configuration changes mid-frame must be ignored.
    mode_pin = ~md;
    lsb_pin  = ~lsb;
    for (int b = 0; b < total; b++) begin
      wi   = b / w;
      sclk = ~cpol;
      if (cpha) mosi = mo[wi][bpos(b, w, lsb)];
      else      mi[wi][bpos(b, w, lsb)] = sel ? miso12 : miso8;
      wait_clk(HALF);
      sclk = cpol;
      if (cpha) mi[wi][bpos(b, w, lsb)] = sel ? miso12 : miso8;
      else if (b + 1 < total) begin
        nb   = b + 1;
        mosi = mo[nb / w][bpos(nb, w, lsb)];
      end
      wait_clk(HALF);
      if (b + 1 == rst_after) begin
        reset = 1'b1;
        wait_clk(3);
        check_reset_outputs("midreset");
        reset = 1'b0;
        wait_clk(2);
        check("busy_after_midreset", 32'(busy8), 32'h0);
      end
    end
    wait_clk(4);
    cs_lvl = 1'b1;
    wait_clk(12);
    mode_pin = md;
    lsb_pin  = lsb;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        sel;     // 0: 8-bit instance, 1: 12-bit instance
    logic [1:0]  md;
    logic        lsb;
    logic [31:0] mo;      // word the master sends
    logic [31:0] tx;      // word preloaded into the slave
    logic [31:0] exp_rx;
    logic [31:0] exp_mi;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int               s, pre_rx, pre_fe, pre_und, n_early;
    logic [2:0][31:0] mo, mi;

    vecs[0] = '{1'b0, 2'd2, 1'b0, 32'hCA,  32'hB3,  32'hCA,  32'hB3};
    vecs[1] = '{1'b0, 2'd0, 1'b0, 32'h5A,  32'h3C,  32'h5A,  32'h3C};
    vecs[2] = '{1'b0, 2'd1, 1'b0, 32'h5A,  32'h3C,  32'h5A,  32'h3C};
    vecs[3] = '{1'b0, 2'd2, 1'b0, 32'h5A,  32'h3C,  32'h5A,  32'h3C};
    vecs[4] = '{1'b0, 2'd3, 1'b0, 32'h5A,  32'h3C,  32'h5A,  32'h3C};
    vecs[5] = '{1'b1, 2'd0, 1'b1, 32'hABC, 32'h5A5, 32'hABC, 32'h5A5};
    vecs[6] = '{1'b0, 2'd1, 1'b1, 32'h2D,  32'hC6,  32'h2D,  32'hC6};

    reset    = 1'b1;
    sclk     = 1'b0;
    mosi     = 1'b0;
    cs_lvl   = 1'b1;
    sel12    = 1'b0;
    mode_pin = 2'd0;
    lsb_pin  = 1'b0;
    tx_word  = '0;
    txv8     = 1'b0;
    txv12    = 1'b0;
    wait_clk(4);
    check_reset_outputs("reset");
    reset = 1'b0;
    wait_clk(10);

    // Single-word frames across modes, bit orders and widths
    for (int i = 0; i < 7; i++) begin
      s      = vecs[i].sel ? 1 : 0;
      pre_rx = rxv_cnt[s];
      pre_fe = fe_cnt[s];
      push_tx(vecs[i].sel, vecs[i].tx);
      mo    = '0;
      mo[0] = vecs[i].mo;
      spi_frame(vecs[i].sel, vecs[i].md, vecs[i].lsb, s ? 12 : 8, 1, mo, -1, -1, mi);
      check($sformatf("v%0d_rx_data", i), s ? 32'(rx_data12) : 32'(rx_data8), vecs[i].exp_rx);
      check($sformatf("v%0d_miso_word", i), mi[0], vecs[i].exp_mi);
      check($sformatf("v%0d_rx_valid_count", i), 32'(rxv_cnt[s] - pre_rx), 32'd1);
      check($sformatf("v%0d_frame_err_count", i), 32'(fe_cnt[s] - pre_fe), 32'd0);
    end

    // Three-word burst with only two transmit words supplied
    pre_rx  = rxv_cnt[0];
    pre_und = und_cnt[0];
    push_tx(1'b0, 32'hA1);
    mo    = '0;
    mo[0] = 32'h11;
    mo[1] = 32'h22;
    mo[2] = 32'h33;
    fork
      spi_frame(1'b0, 2'd3, 1'b0, 8, 3, mo, -1, -1, mi);
      begin
        wait_clk(40);
        push_tx(1'b0, 32'hA2);
      end
    join
    check("burst_rx_valid_count", 32'(rxv_cnt[0] - pre_rx), 32'd3);
    check("burst_rx_word0", rx_log[0][(pre_rx + 0) % 16], 32'h11);
    check("burst_rx_word1", rx_log[0][(pre_rx + 1) % 16], 32'h22);
    check("burst_rx_word2", rx_log[0][(pre_rx + 2) % 16], 32'h33);
    check("burst_miso_word0", mi[0], 32'hA1);
    check("burst_miso_word1", mi[1], 32'hA2);
    check("burst_miso_word2", mi[2], 32'h00);
    n_early = 0;
    for (int j = pre_und; j < und_cnt[0]; j++)
      if (und_at[0][j % 16] - pre_rx <= 2) n_early++;
    check("burst_underrun_by_word3", 32'(n_early), 32'd1);
    check("burst_underrun_at_word3", 32'(und_at[0][pre_und % 16] - pre_rx), 32'd2);

    // CS deasserted after 5 bits, then a clean frame
    pre_rx = rxv_cnt[0];
    pre_fe = fe_cnt[0];
    push_tx(1'b0, 32'h55);
    mo    = '0;
    mo[0] = 32'hFF;
    spi_frame(1'b0, 2'd0, 1'b0, 8, 1, mo, 5, -1, mi);
    check("abort_frame_err_count", 32'(fe_cnt[0] - pre_fe), 32'd1);
    check("abort_rx_valid_count", 32'(rxv_cnt[0] - pre_rx), 32'd0);
    check("abort_rx_data_held", 32'(rx_data8), 32'h33);

    pre_rx = rxv_cnt[0];
    pre_fe = fe_cnt[0];
    push_tx(1'b0, 32'h69);
    mo[0] = 32'h96;
    spi_frame(1'b0, 2'd0, 1'b0, 8, 1, mo, -1, -1, mi);
    check("after_abort_rx_data", 32'(rx_data8), 32'h96);
    check("after_abort_miso", mi[0], 32'h69);
    check("after_abort_rx_valid_count", 32'(rxv_cnt[0] - pre_rx), 32'd1);
    check("after_abort_frame_err_count", 32'(fe_cnt[0] - pre_fe), 32'd0);

    // Reset after 3 bits with CS held low: the rest of the frame is ignored
    pre_rx = rxv_cnt[0];
    pre_fe = fe_cnt[0];
    mo[0]  = 32'hA5;
    spi_frame(1'b0, 2'd0, 1'b0, 8, 1, mo, -1, 3, mi);
    check("reset_frame_rx_valid_count", 32'(rxv_cnt[0] - pre_rx), 32'd0);
    check("reset_frame_frame_err_count", 32'(fe_cnt[0] - pre_fe), 32'd0);
    check("reset_frame_rx_data", 32'(rx_data8), 32'h00);

    pre_rx = rxv_cnt[0];
    push_tx(1'b0, 32'h0F);
    mo[0] = 32'hF0;
    spi_frame(1'b0, 2'd0, 1'b0, 8, 1, mo, -1, -1, mi);
    check("post_reset_rx_data", 32'(rx_data8), 32'hF0);
    check("post_reset_miso", mi[0], 32'h0F);
    check("post_reset_rx_valid_count", 32'(rxv_cnt[0] - pre_rx), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
